fetch_queue_stage: RTL and testbench

- Parametrised next-generation instruction fetch stage for the MIPS pipeline.
- Contains the PC, a debug-loadable synchronous instruction memory, and a redirect mux (register/branch/jump).
- Adds a DEPTH-entry fetch queue with a valid/ready handshake toward decode, redirect flush, and halt-instruction detection.
- Sits between the debug unit and the IF/ID boundary.

---
 rtl/fetch_queue_stage.sv | 229 ++++++++++++++++++++++
 tb/tb_fetch_queue_stage.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_stage.sv
// ---------------------------------------------------------------------------
// fetch_queue_stage
//
// Instruction fetch stage for the MIPS pipeline. It holds the fetch PC, a
// synchronous instruction memory that the debug unit can load, and a redirect
// mux that selects a register, branch or jump target. Fetched instructions go
// into a small fetch queue, and decode drains that queue through a
// valid/ready handshake. A redirect flushes the queue. Fetch stops once a
// halt instruction has been captured.
//
// Ports
//   i_clock          system clock
//   i_reset          synchronous, active-high reset
//   i_enable         pipeline enable; low freezes issue, pop and redirect
//   i_dbg_mode       debug mode: issue suspended, memory writable
//   i_mem_wen        memory write strobe (only honoured in debug mode)
//   i_mem_wr_addr    memory write word address
//   i_mem_wr_data    memory write data
//   i_redirect       redirect request (taken branch / jump)
//   i_redirect_src   0=register, 1=branch, 2/3=jump
//   i_addr_register  register target address
//   i_addr_branch    branch target address
//   i_addr_jump      jump target address
//   i_ready          decode accepts the head entry
//   o_valid          queue head is valid
//   o_instruction    head instruction (0 when empty)
//   o_pc_next        head PC+1 (0 when empty)
//   o_pc             current fetch PC
//   o_halted         halt instruction captured, issue stopped
//   o_fq_count       number of occupied queue entries
// ---------------------------------------------------------------------------
module fetch_queue_stage #(
  parameter int          NB_INST     = 32,
  parameter int          NB_ADDR     = 10,
  parameter int          FQ_DEPTH    = 4,
  parameter logic [5:0]  HALT_OPCODE = 6'b111111,
  localparam int         NB_COUNT    = $clog2(FQ_DEPTH + 1)
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic                i_dbg_mode,
  input  logic                i_mem_wen,
  input  logic [NB_ADDR-1:0]  i_mem_wr_addr,
  input  logic [NB_INST-1:0]  i_mem_wr_data,
  input  logic                i_redirect,
  input  logic [1:0]          i_redirect_src,
  input  logic [NB_ADDR-1:0]  i_addr_register,
  input  logic [NB_ADDR-1:0]  i_addr_branch,
  input  logic [NB_ADDR-1:0]  i_addr_jump,
  input  logic                i_ready,
  output logic                o_valid,
  output logic [NB_INST-1:0]  o_instruction,
  output logic [NB_ADDR-1:0]  o_pc_next,
  output logic [NB_ADDR-1:0]  o_pc,
  output logic                o_halted,
  output logic [NB_COUNT-1:0] o_fq_count
);

  localparam int                 MEM_WORDS   = 2 ** NB_ADDR;
  localparam int                 NB_PTR      = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam logic [NB_PTR-1:0]  LAST_SLOT   = NB_PTR'(FQ_DEPTH - 1);
  localparam logic [NB_COUNT:0]  DEPTH_LIMIT = (NB_COUNT + 1)'(FQ_DEPTH);

  logic [NB_INST-1:0]  r_mem [MEM_WORDS];
  logic [NB_INST-1:0]  r_rdData;

  logic [NB_ADDR-1:0]  r_pc;
  logic                r_inflight;
  logic [NB_ADDR-1:0]  r_inflightPc;
  logic                r_halted;

  logic [NB_INST-1:0]  r_fqInst [FQ_DEPTH];
  logic [NB_ADDR-1:0]  r_fqPcNext [FQ_DEPTH];
  logic [NB_PTR-1:0]   r_head;
  logic [NB_PTR-1:0]   r_tail;
  logic [NB_COUNT-1:0] r_count;

  logic                w_redirect;
  logic [NB_ADDR-1:0]  w_target;
  logic [NB_COUNT:0]   w_reserved;
  logic                w_hasSpace;
  logic                w_issue;
  logic                w_push;
  logic                w_pushHalt;
  logic                w_valid;
  logic                w_pop;

  // Advances a queue pointer. The queue depth need not be a power of two, so
  // the wrap back to slot 0 is explicit.
  function automatic logic [NB_PTR-1:0] nextSlot(input logic [NB_PTR-1:0] ptr);
    if (ptr == LAST_SLOT) begin
      return '0;
    end
    return ptr + NB_PTR'(1);
  endfunction

  // Redirect target selection. The reserved source code 3 behaves like a
  // jump, so any source other than register or branch picks the jump target.
  always_comb begin
    w_target = i_addr_jump;
    case (i_redirect_src)
      2'd0:    w_target = i_addr_register;
      2'd1:    w_target = i_addr_branch;
      default: w_target = i_addr_jump;
    endcase
  end

  // Control decisions for this cycle. A queue slot is reserved when a read is
  // issued, so occupancy plus the outstanding read must stay below the depth.
  // A returning read is therefore always accepted, even while the pipeline is
  // frozen. It is dropped only when a redirect discards it, or when a halt has
  // already been captured (the read was issued in the same cycle the halt was
  // pushed). A redirect wins over both push and pop.
  always_comb begin
    w_redirect = i_enable & i_redirect;
    w_reserved = {1'b0, r_count} + {{NB_COUNT{1'b0}}, r_inflight};
    w_hasSpace = (w_reserved < DEPTH_LIMIT);
    w_issue    = i_enable & ~i_dbg_mode & ~r_halted & ~w_redirect & w_hasSpace;
    w_push     = r_inflight & ~r_halted & ~w_redirect;
    w_pushHalt = w_push & (r_rdData[NB_INST-1 -: 6] == HALT_OPCODE);
    w_valid    = (r_count != '0);
    w_pop      = w_valid & i_ready & i_enable & ~w_redirect;
  end

  // Debug-unit write port. Reset has priority, so a write strobe that is
  // asserted together with reset is dropped. The contents are never cleared.
  always_ff @(posedge i_clock) begin
    if (!i_reset && i_dbg_mode && i_mem_wen) begin
      r_mem[i_mem_wr_addr] <= i_mem_wr_data;
    end
  end

  // Synchronous read port with one cycle of latency. It is loaded only on
  // issue, so the registered word stays tied to the PC in r_inflightPc.
  always_ff @(posedge i_clock) begin
    if (w_issue) begin
      r_rdData <= r_mem[r_pc];
    end
  end

  // Fetch PC. A redirect loads the selected target and an issue steps to the
  // next word. The address width makes the step wrap from the top word to 0.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_pc <= '0;
    end else if (w_redirect) begin
      r_pc <= w_target;
    end else if (w_issue) begin
      r_pc <= r_pc + NB_ADDR'(1);
    end
  end

  // Outstanding read tracker. It is set only for the cycle after an issue,
  // because the memory always answers one cycle later. A redirect never
  // issues, so the flag also clears on a redirect edge and the old read is
  // lost along with the flushed queue.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_inflight   <= 1'b0;
      r_inflightPc <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflightPc <= r_pc;
      end
    end
  end

  // Halt flag. It is set on the edge that pushes a halt instruction into the
  // queue. A redirect restarts fetch and so clears it.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_halted <= 1'b0;
    end else if (w_redirect) begin
      r_halted <= 1'b0;
    end else if (w_pushHalt) begin
      r_halted <= 1'b1;
    end
  end

  // Queue payload storage. Each slot keeps the instruction and its PC+1, so
  // the head entry can be presented without any further arithmetic.
  always_ff @(posedge i_clock) begin
    if (!i_reset && w_push) begin
      r_fqInst[r_tail]   <= r_rdData;
      r_fqPcNext[r_tail] <= r_inflightPc + NB_ADDR'(1);
    end
  end

  // Queue pointers and occupancy. A flush simply rewinds both pointers. A
  // push and a pop on the same edge move both pointers and leave the count
  // unchanged.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (w_redirect) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tail <= nextSlot(r_tail);
      end
      if (w_pop) begin
        r_head <= nextSlot(r_head);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + NB_COUNT'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - NB_COUNT'(1);
      end
    end
  end

  // Head presentation. The payload is forced to zero while the queue is
  // empty, so stale slot contents never reach decode.
  always_comb begin
    o_valid       = w_valid;
    o_instruction = w_valid ? r_fqInst[r_head]   : '0;
    o_pc_next     = w_valid ? r_fqPcNext[r_head] : '0;
    o_pc          = r_pc;
    o_halted      = r_halted;
    o_fq_count    = r_count;
  end

endmodule

// File: tb/tb_fetch_queue_stage.sv
module tb_fetch_queue_stage;

  localparam int NB_INST    = 32;
  localparam int NB_ADDR    = 10;
  localparam int FQ_DEPTH   = 4;
  localparam int NB_COUNT   = $clog2(FQ_DEPTH + 1);
  localparam int MEM_WORDS  = 1 << NB_ADDR;
  localparam int STREAM_LEN = 200;

  logic                i_clock = 1'b0;
  logic                i_reset = 1'b1;
  logic                i_enable = 1'b0;
  logic                i_dbg_mode = 1'b1;
  logic                i_mem_wen = 1'b0;
  logic [NB_ADDR-1:0]  i_mem_wr_addr = '0;
  logic [NB_INST-1:0]  i_mem_wr_data = '0;
  logic                i_redirect = 1'b0;
  logic [1:0]          i_redirect_src = 2'd0;
  logic [NB_ADDR-1:0]  i_addr_register = '0;
  logic [NB_ADDR-1:0]  i_addr_branch = '0;
  logic [NB_ADDR-1:0]  i_addr_jump = '0;
  logic                i_ready = 1'b0;
  logic                o_valid;
  logic [NB_INST-1:0]  o_instruction;
  logic [NB_ADDR-1:0]  o_pc_next;
  logic [NB_ADDR-1:0]  o_pc;
  logic                o_halted;
  logic [NB_COUNT-1:0] o_fq_count;

  always #5 i_clock = ~i_clock;

  fetch_queue_stage #(
    .NB_INST    (NB_INST),
    .NB_ADDR    (NB_ADDR),
    .FQ_DEPTH   (FQ_DEPTH),
    .HALT_OPCODE(6'b111111)
  ) dut (
    .i_clock        (i_clock),
    .i_reset        (i_reset),
    .i_enable       (i_enable),
    .i_dbg_mode     (i_dbg_mode),
    .i_mem_wen      (i_mem_wen),
    .i_mem_wr_addr  (i_mem_wr_addr),
    .i_mem_wr_data  (i_mem_wr_data),
    .i_redirect     (i_redirect),
    .i_redirect_src (i_redirect_src),
    .i_addr_register(i_addr_register),
    .i_addr_branch  (i_addr_branch),
    .i_addr_jump    (i_addr_jump),
    .i_ready        (i_ready),
    .o_valid        (o_valid),
    .o_instruction  (o_instruction),
    .o_pc_next      (o_pc_next),
    .o_pc           (o_pc),
    .o_halted       (o_halted),
    .o_fq_count     (o_fq_count)
  );

  typedef struct packed {
    logic [NB_INST-1:0] inst;
    logic [NB_ADDR-1:0] pcNext;
  } expEntry_t;

  expEntry_t          expQ[$];
  logic [NB_INST-1:0] modelMem [MEM_WORDS];
  int                 checks = 0;
  int                 failures = 0;

  // Reference program model: instructions leave the stage in program order,
  // starting at the fetch start address and ending after a halt word.
  function automatic bit isHalt(input logic [NB_INST-1:0] w);
    return (w[NB_INST-1 -: 6] == 6'b111111);
  endfunction

  function automatic logic [NB_ADDR-1:0] pickTarget(input logic [1:0] src,
                                                    input logic [NB_ADDR-1:0] regT,
                                                    input logic [NB_ADDR-1:0] brT,
                                                    input logic [NB_ADDR-1:0] jmpT);
    if (src == 2'd0) return regT;
    if (src == 2'd1) return brT;
    return jmpT;
  endfunction

  task automatic startStream(input logic [NB_ADDR-1:0] start);
    logic [NB_ADDR-1:0] a;
    expEntry_t e;
    a = start;
    for (int n = 0; n < STREAM_LEN; n++) begin
      e.inst   = modelMem[a];
      e.pcNext = a + NB_ADDR'(1);
      expQ.push_back(e);
      if (isHalt(e.inst)) break;
      a = e.pcNext;
    end
  endtask

  // Applies the current inputs for a number of cycles and keeps the model in
  // step: reset flushes it, a taken redirect restarts the expected stream,
  // and debug writes update the shadow memory.
  task automatic applyStimulus(input int nCycles);
    for (int c = 0; c < nCycles; c++) begin
      if (i_reset) begin
        expQ.delete();
      end else begin
        if (i_enable && i_redirect) begin
          expQ.delete();
          startStream(pickTarget(i_redirect_src, i_addr_register, i_addr_branch, i_addr_jump));
        end
        if (i_dbg_mode && i_mem_wen) modelMem[i_mem_wr_addr] = i_mem_wr_data;
      end
      @(posedge i_clock);
      #1;
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s got=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic setTargets(input logic [1:0] src, input int regT, input int brT, input int jmpT);
    i_redirect_src  = src;
    i_addr_register = NB_ADDR'(regT);
    i_addr_branch   = NB_ADDR'(brT);
    i_addr_jump     = NB_ADDR'(jmpT);
  endtask

  // Monitor: every handshake that decode completes is compared against the
  // next entry that the model expects.
  always @(negedge i_clock) begin
    expEntry_t e;
    if (!i_reset && o_valid && i_ready && i_enable && !i_redirect) begin
      checks++;
      if (expQ.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_pop got inst=%h pc_next=%h expected no entry", o_instruction, o_pc_next);
      end else begin
        e = expQ.pop_front();
        if (o_instruction !== e.inst || o_pc_next !== e.pcNext) begin
          failures++;
          $display("[TB] FAIL pop_compare got inst=%h pc_next=%h expected inst=%h pc_next=%h",
                   o_instruction, o_pc_next, e.inst, e.pcNext);
        end
      end
    end
  end

  initial begin
    logic [NB_ADDR-1:0] pcHold;
    logic [NB_INST-1:0] instHold;
    logic [NB_INST-1:0] w;
    int since;

    for (int a = 0; a < MEM_WORDS; a++) modelMem[a] = '0;

    // Reset state
    applyStimulus(2);
    checkOutput("reset_valid", 32'(o_valid), 0);
    checkOutput("reset_instruction", o_instruction, 0);
    checkOutput("reset_pc_next", 32'(o_pc_next), 0);
    checkOutput("reset_pc", 32'(o_pc), 0);
    checkOutput("reset_halted", 32'(o_halted), 0);
    checkOutput("reset_count", 32'(o_fq_count), 0);
    i_reset = 1'b0;
    applyStimulus(1);

    // Debug load of a three-word program ending in halt
    i_mem_wen = 1'b1;
    i_mem_wr_addr = 10'd0; i_mem_wr_data = 32'h3C01000A; applyStimulus(1);
    i_mem_wr_addr = 10'd1; i_mem_wr_data = 32'h3C020014; applyStimulus(1);
    i_mem_wr_addr = 10'd2; i_mem_wr_data = 32'hFC000000; applyStimulus(1);
    i_mem_wen = 1'b0;
    startStream(10'd0);
    i_dbg_mode = 1'b0; i_enable = 1'b1; i_ready = 1'b1;
    applyStimulus(1);
    checkOutput("first_issue_valid_low", 32'(o_valid), 0);
    applyStimulus(1);
    checkOutput("first_issue_valid_high", 32'(o_valid), 1);
    applyStimulus(8);
    checkOutput("halt_flag", 32'(o_halted), 1);
    checkOutput("halt_valid_low", 32'(o_valid), 0);
    checkOutput("halt_pc_bound", 32'(o_pc <= 10'd4), 1);
    checkOutput("halt_stream_drained", 32'(expQ.size()), 0);

    // Full random memory image; low and top regions free of halts, halt at 100
    i_dbg_mode = 1'b1; i_mem_wen = 1'b1;
    for (int a = 0; a < MEM_WORDS; a++) begin
      w = $urandom;
      if (a < 64 || a >= 1000 || (a >= 96 && a < 100)) w[31] = 1'b0;
      else if ($urandom_range(0, 31) == 0) w[31:26] = 6'b111111;
      if (a == 100) w[31:26] = 6'b111111;
      i_mem_wr_addr = NB_ADDR'(a); i_mem_wr_data = w;
      applyStimulus(1);
    end
    i_mem_wen = 1'b0;
    i_reset = 1'b1; applyStimulus(1); i_reset = 1'b0;
    checkOutput("reset_clears_halt", 32'(o_halted), 0);

    // Back-pressure: queue saturates, then drains in order
    startStream(10'd0);
    i_dbg_mode = 1'b0; i_ready = 1'b0;
    applyStimulus(8);
    checkOutput("bp_count_full", 32'(o_fq_count), FQ_DEPTH);
    checkOutput("bp_pc", 32'(o_pc), 4);
    checkOutput("bp_valid", 32'(o_valid), 1);
    i_ready = 1'b1;
    applyStimulus(6);

    // Redirects through every source
    setTargets(2'd1, 33, 12, 44); i_redirect = 1'b1; applyStimulus(1); i_redirect = 1'b0;
    checkOutput("redir_flush_count", 32'(o_fq_count), 0);
    checkOutput("redir_valid_low", 32'(o_valid), 0);
    checkOutput("redir_pc_target", 32'(o_pc), 12);
    applyStimulus(1);
    checkOutput("redir_pc_step", 32'(o_pc), 13);
    applyStimulus(6);
    setTargets(2'd0, 30, 51, 52); i_redirect = 1'b1; applyStimulus(1); i_redirect = 1'b0;
    applyStimulus(6);
    setTargets(2'd2, 40, 41, 8); i_redirect = 1'b1; applyStimulus(1); i_redirect = 1'b0;
    i_ready = 1'b0;
    applyStimulus(6);
    setTargets(2'd3, 45, 46, 20); i_redirect = 1'b1; applyStimulus(1); i_redirect = 1'b0;
    i_ready = 1'b1;
    applyStimulus(8);

    // Enable freeze with an ignored redirect request
    pcHold = o_pc;
    i_enable = 1'b0; setTargets(2'd2, 500, 501, 502); i_redirect = 1'b1;
    applyStimulus(1);
    instHold = o_instruction;
    applyStimulus(2);
    checkOutput("freeze_pc_stable", 32'(o_pc), 32'(pcHold));
    checkOutput("freeze_head_stable", o_instruction, instHold);
    checkOutput("freeze_absorb_one", 32'(o_fq_count), 2);
    i_redirect = 1'b0; i_enable = 1'b1;
    applyStimulus(6);

    // Debug mode: issue stops, pops continue
    i_dbg_mode = 1'b1;
    applyStimulus(1);
    pcHold = o_pc;
    applyStimulus(3);
    checkOutput("dbg_pc_held", 32'(o_pc), 32'(pcHold));
    checkOutput("dbg_drained", 32'(o_valid), 0);
    i_dbg_mode = 1'b0;
    applyStimulus(6);

    // Address wrap at the top of memory
    setTargets(2'd2, 3, 4, 1022); i_redirect = 1'b1; applyStimulus(1); i_redirect = 1'b0;
    applyStimulus(8);

    // Reset with a partly full queue and halt captured
    setTargets(2'd1, 7, 98, 9); i_redirect = 1'b1; i_ready = 1'b0;
    applyStimulus(1); i_redirect = 1'b0;
    applyStimulus(8);
    checkOutput("pre_reset_count", 32'(o_fq_count), 3);
    checkOutput("pre_reset_halted", 32'(o_halted), 1);
    i_reset = 1'b1; i_dbg_mode = 1'b1; i_mem_wen = 1'b1;
    i_mem_wr_addr = 10'd0; i_mem_wr_data = 32'hDEADBEEF; i_redirect = 1'b1;
    applyStimulus(1);
    checkOutput("rst_valid", 32'(o_valid), 0);
    checkOutput("rst_instruction", o_instruction, 0);
    checkOutput("rst_pc_next", 32'(o_pc_next), 0);
    checkOutput("rst_pc", 32'(o_pc), 0);
    checkOutput("rst_halted", 32'(o_halted), 0);
    checkOutput("rst_count", 32'(o_fq_count), 0);
    i_reset = 1'b0; i_dbg_mode = 1'b0; i_mem_wen = 1'b0; i_redirect = 1'b0; i_ready = 1'b1;
    startStream(10'd0);
    applyStimulus(10);

    // Randomized traffic
    since = 0;
    for (int c = 0; c < 3000; c++) begin
      i_ready    = ($urandom_range(0, 9) < 7);
      i_enable   = ($urandom_range(0, 9) != 0);
      i_redirect = ($urandom_range(0, 19) == 0) || (since >= 50);
      if (i_redirect) begin
        setTargets(2'($urandom_range(0, 3)), $urandom_range(0, MEM_WORDS - 1),
                   $urandom_range(0, MEM_WORDS - 1), $urandom_range(0, MEM_WORDS - 1));
      end
      if (i_enable && i_redirect) since = 0;
      else since++;
      applyStimulus(1);
    end
    i_redirect = 1'b0; i_enable = 1'b1; i_ready = 1'b1;
    applyStimulus(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
